// File: rtl/apb_master.sv
// APB initiator: converts a single-outstanding CPU request/response
// handshake into APB SETUP/ACCESS transfers. An ACCESS watchdog aborts
// transfers that never see pready_cpu and reports them with rsp_err.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no transfer in flight; req_ready high, accepts a request
// SETUP  | psel_cpu high, penable low; address/control presented
// ACCESS | psel_cpu and penable high; waiting for pready_cpu or timeout
module apb_master #(
  parameter int APB_ADDR_W = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel_cpu,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata_cpu,
  input  logic                  pready_cpu
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last ACCESS cycle index that may still wait before the watchdog fires.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tcnt;

  // Ready depends on state only, so there is no path from req_valid.
  assign req_ready = (state == IDLE);

  // Transfer sequencing, watchdog and all registered outputs.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= IDLE;
      tcnt      <= 8'd0;
      psel_cpu  <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            pwrite   <= req_write;
            paddr    <= req_addr;
            pwdata   <= req_wdata;
            psel_cpu <= 1'b1;
            penable  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          tcnt    <= 8'd0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A late pready wins over the watchdog in the same cycle.
          if (pready_cpu) begin
            psel_cpu  <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? 32'd0 : prdata_cpu;
            state     <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            psel_cpu  <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
          psel_cpu <= 1'b0;
          penable  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master. The driver computes each
// transfer's expected outcome from the wait-state count it assigns to the
// responder; a responder process plays the APB target and a monitor pops
// and checks every completion.
module tb_apb_master;

  localparam int AW = 16;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          psel_cpu;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata_cpu;
  logic          pready_cpu;

  apb_master #(.APB_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel_cpu(psel_cpu), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata_cpu(prdata_cpu), .pready_cpu(pready_cpu)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    int            w;
    int            acc;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          pen;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  plan_t cur;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    k = 0;
  int    pen_cnt = 0;
  int    prev_rsp = 0;

  // Cycle index; read #1 after an edge or on the falling edge.
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request. w = ACCESS cycles with pready low before it rises
  // (w >= TO means the target never answers in time).
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int w, input int gap);
    plan_t p;
    exp_t  e;
    int    waited;
    bit    timeout;
    repeat (gap) @(negedge pclk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    waited = 0;
    while (!req_ready) begin
      @(negedge pclk);
      waited++;
      if (waited > 400) begin
        $display("FAIL req_accept_timeout: req_ready never rose (cycle %0d)", cyc);
        $fatal(1, "request never accepted");
      end
    end
    @(posedge pclk);
    #1;
    if (gap == 0) chk("b2b_accept_cycle", cyc, prev_rsp + 1);
    timeout = (w >= TO);
    p.wr = wr; p.addr = addr; p.wdata = wdata; p.rdata = rdata; p.w = w; p.acc = cyc;
    e.err   = timeout;
    e.rdata = (timeout || wr) ? 32'd0 : rdata;
    e.cyc   = timeout ? cyc + 1 + TO : cyc + 2 + w;
    e.pen   = timeout ? TO : w + 1;
    plan_q.push_back(p);
    exp_q.push_back(e);
    prev_rsp = e.cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 2000)) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // APB target model: follows the plan of the transfer in SETUP.
  always @(negedge pclk) begin
    if (!presetn) begin
      pready_cpu = 1'b0;
    end else if (psel_cpu && !penable) begin
      if (plan_q.size() == 0) begin
        chk("unexpected_setup", 32'd1, 32'd0);
      end else begin
        cur = plan_q.pop_front();
        k = 0;
        pen_cnt = 0;
        chk("setup_cycle", cyc, cur.acc);
        chk("setup_paddr", 32'(paddr), 32'(cur.addr));
        chk("setup_pwrite", 32'(pwrite), 32'(cur.wr));
        chk("setup_pwdata", pwdata, cur.wdata);
      end
      prdata_cpu = cur.rdata;
      pready_cpu = 1'($urandom % 2);
    end else if (psel_cpu && penable) begin
      chk("access_paddr", 32'(paddr), 32'(cur.addr));
      chk("access_pwrite", 32'(pwrite), 32'(cur.wr));
      chk("access_pwdata", pwdata, cur.wdata);
      pen_cnt++;
      pready_cpu = (k == cur.w);
      k++;
    end else begin
      if (penable) chk("penable_without_psel", 32'd1, 32'd0);
      pready_cpu = 1'($urandom % 2);
      prdata_cpu = $urandom;
    end
  end

  // Scoreboard monitor: every completion must match the next expectation.
  always @(negedge pclk) begin
    exp_t e;
    if (presetn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", cyc, e.cyc);
        chk("penable_cycles", pen_cnt, e.pen);
        chk("rsp_psel_low", 32'(psel_cpu), 32'd0);
        chk("rsp_req_ready", 32'(req_ready), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    presetn    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    prdata_cpu = 32'd0;
    pready_cpu = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_psel", 32'(psel_cpu), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Directed cases from the plan.
    do_txn(1'b0, 16'h0804, 32'd0, 32'hDEADBEEF, 0, 1);
    do_txn(1'b1, 16'h1800, 32'h0000_00A5, $urandom, 2, 1);
    do_txn(1'b0, 16'h2000, 32'd0, $urandom, 255, 1);
    do_txn(1'b0, 16'h2004, 32'd0, 32'h1234_5678, TO - 1, 1);
    do_txn(1'b0, 16'h2008, 32'd0, 32'h0BAD_F00D, TO, 1);
    do_txn(1'b1, 16'h0100, 32'h1111_2222, $urandom, 0, 1);
    do_txn(1'b0, 16'h0104, 32'd0, 32'h3333_4444, 1, 0);
    do_txn(1'b0, 16'h0108, 32'd0, 32'h5555_6666, 0, 0);

    // Randomized mix of wait states, timeouts and gaps.
    for (int i = 0; i < 60; i++) begin
      int sel;
      int w;
      sel = int'($urandom % 8);
      case (sel)
        4: w = TO - 1;
        5: w = TO;
        6: w = 200;
        7: w = int'($urandom % 20);
        default: w = int'($urandom % 4);
      endcase
      do_txn(1'($urandom % 2), AW'($urandom), $urandom, $urandom, w, int'($urandom % 3));
    end
    drain();

    // Reset during ACCESS of a stalled write.
    do_txn(1'b1, 16'h4444, 32'hCAFE_0001, $urandom, 255, 2);
    n = 0;
    while (!penable && (n < 50)) begin
      @(negedge pclk);
      n++;
    end
    chk("midrst_reached_access", 32'(penable), 32'd1);
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    exp_q.delete();
    chk("midrst_psel", 32'(psel_cpu), 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_pwrite", 32'(pwrite), 32'd0);
    chk("midrst_paddr", 32'(paddr), 32'd0);
    chk("midrst_pwdata", pwdata, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge pclk);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // Recovery transfer after the aborted one.
    do_txn(1'b0, 16'h0010, 32'd0, 32'h0F0F_F0F0, 1, 1);
    drain();
    repeat (3) @(negedge pclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
